// File: rtl/spram_arbiter_pkg.sv
// Types and helpers shared by the spram8 arbiter and its response pipeline.
package spram_arbiter_pkg;

  `include "spram_arb_defs.vh"

  // One entry of the read-response pipeline: is it a read, and who asked.
  typedef struct packed {
    logic valid;
    logic port;
  } rsp_tag_t;

  // Grant decision, returned as {grant_b, grant_a}. At most one bit is set,
  // and a bit is never set without its valid.
  function automatic logic [1:0] arb_grant(input logic av, input logic bv,
                                           input logic ptr, input int mode);
    logic ga;
    logic gb;
    if (mode == ARB_RR) begin
      ga = av & (~bv | (ptr == PORT_A));
      gb = bv & (~av | (ptr == PORT_B));
    end else begin
      ga = av;
      gb = bv & ~av;
    end
    return {gb, ga};
  endfunction

endpackage

// File: rtl/spram_arb_defs.vh
// Shared constants for the spram8 arbiter: port ids, arbitration modes
// and the idle encoding of the active-low memory control pins.
localparam logic PORT_A    = 1'b0;
localparam logic PORT_B    = 1'b1;

localparam int   ARB_RR    = 0;
localparam int   ARB_FIXED = 1;

localparam logic IDLE_CS_N = 1'b1;
localparam logic IDLE_WE_N = 1'b1;
localparam logic IDLE_OE_N = 1'b1;

// File: rtl/spram_rsp_pipe.sv
// Shift register of read tags; the last stage lines up with spram8 data_out.
module spram_rsp_pipe
  import spram_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t i_tag,
  output rsp_tag_t o_tag
);

  rsp_tag_t r_stage [DEPTH];

  // First stage captures the tag of the request accepted on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_stage[0] <= '0;
    else        r_stage[0] <= i_tag;
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      // Each later stage delays the tag by one more clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stage[gi] <= '0;
        else        r_stage[gi] <= r_stage[gi-1];
      end
    end
  endgenerate

  assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/spram_arbiter.sv
// Two-port valid/ready arbiter in front of a single spram8 instance.
// Pins are driven from registers; read data returns RD_LAT+1 edges after accept.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_cs_n,
  output logic          mem_we_n,
  output logic          mem_oe_n,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int MODE = (ARB_MODE == ARB_FIXED) ? ARB_FIXED : ARB_RR;

  logic          r_rr_ptr;
  logic [1:0]    w_grant;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          w_accept;
  logic          w_sel_port;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  rsp_tag_t      w_tag_in;
  rsp_tag_t      w_tag_out;

  logic          r_mem_cs_n;
  logic          r_mem_we_n;
  logic          r_mem_oe_n;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_din;
  logic          r_a_rvalid;
  logic          r_b_rvalid;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  assign w_grant   = arb_grant(a_valid, b_valid, r_rr_ptr, MODE);
  assign w_grant_a = w_grant[0];
  assign w_grant_b = w_grant[1];
  assign w_accept  = w_grant_a | w_grant_b;
  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;

  // Mux the granted request onto a single internal request.
  always_comb begin
    w_sel_port  = PORT_A;
    w_sel_we    = a_we;
    w_sel_addr  = a_addr;
    w_sel_wdata = a_wdata;
    if (w_grant_b) begin
      w_sel_port  = PORT_B;
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end
  end

  // Round-robin pointer hands priority to the other port after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_rr_ptr <= PORT_A;
    else if (w_grant_a) r_rr_ptr <= PORT_B;
    else if (w_grant_b) r_rr_ptr <= PORT_A;
  end

  // Register the memory pins; address and data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_cs_n <= IDLE_CS_N;
      r_mem_we_n <= IDLE_WE_N;
      r_mem_oe_n <= IDLE_OE_N;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else if (w_accept) begin
      r_mem_cs_n <= 1'b0;
      r_mem_we_n <= ~w_sel_we;
      r_mem_oe_n <= w_sel_we;
      r_mem_addr <= w_sel_addr;
      if (w_sel_we) r_mem_din <= w_sel_wdata;
    end else begin
      r_mem_cs_n <= IDLE_CS_N;
      r_mem_we_n <= IDLE_WE_N;
      r_mem_oe_n <= IDLE_OE_N;
    end
  end

  assign mem_cs_n = r_mem_cs_n;
  assign mem_we_n = r_mem_we_n;
  assign mem_oe_n = r_mem_oe_n;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

  assign w_tag_in.valid = w_accept & ~w_sel_we;
  assign w_tag_in.port  = w_sel_port;

  spram_rsp_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rsp_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  // Steer returning read data to the port that issued the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_tag_out.valid & (w_tag_out.port == PORT_A);
      r_b_rvalid <= w_tag_out.valid & (w_tag_out.port == PORT_B);
      if (w_tag_out.valid && w_tag_out.port == PORT_A) r_a_rdata <= mem_dout;
      if (w_tag_out.valid && w_tag_out.port == PORT_B) r_b_rdata <= mem_dout;
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: round-robin instance with a spram8 model,
// plus a fixed-priority instance used for the starvation/priority checks.
module tb_spram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [14:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ready, b_ready, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        mem_cs_n, mem_we_n, mem_oe_n;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = '0;

  logic        fx_a_valid = 1'b0, fx_b_valid = 1'b0;
  logic [14:0] fx_a_addr = 15'h0011, fx_b_addr = 15'h0055;
  logic        fx_we = 1'b0;
  logic [7:0]  fx_wdata = '0;
  logic [7:0]  fx_mem_dout = '0;
  logic        fx_a_ready, fx_b_ready, fx_a_rvalid, fx_b_rvalid;
  logic [7:0]  fx_a_rdata, fx_b_rdata;
  logic        fx_cs_n, fx_we_n, fx_oe_n;
  logic [14:0] fx_mem_addr;
  logic [7:0]  fx_mem_din;

  spram_arbiter #(.AW(15), .DW(8), .RD_LAT(1), .ARB_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  spram_arbiter #(.AW(15), .DW(8), .RD_LAT(1), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .a_valid(fx_a_valid), .a_ready(fx_a_ready), .a_we(fx_we), .a_addr(fx_a_addr),
    .a_wdata(fx_wdata), .a_rvalid(fx_a_rvalid), .a_rdata(fx_a_rdata),
    .b_valid(fx_b_valid), .b_ready(fx_b_ready), .b_we(fx_we), .b_addr(fx_b_addr),
    .b_wdata(fx_wdata), .b_rvalid(fx_b_rvalid), .b_rdata(fx_b_rdata),
    .mem_cs_n(fx_cs_n), .mem_we_n(fx_we_n), .mem_oe_n(fx_oe_n),
    .mem_addr(fx_mem_addr), .mem_din(fx_mem_din), .mem_dout(fx_mem_dout)
  );

  // spram8 model: samples on the rising edge, registered read of one clock.
  logic [7:0] mem_arr [0:32767];
  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (!mem_we_n)      mem_arr[mem_addr] <= mem_din;
      else if (!mem_oe_n) mem_dout <= mem_arr[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected read responses, in grant order, with the cycle they must appear.
  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic       mon_en = 1'b0;
  logic [7:0] ea_rdata = '0, eb_rdata = '0;

  always @(negedge clk) begin : mon_blk
    logic exp_av;
    logic exp_bv;
    exp_t e;
    exp_av = 1'b0;
    exp_bv = 1'b0;
    if (mon_en) begin
      if (!rst_n) begin
        exp_q.delete();
        ea_rdata = '0;
        eb_rdata = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          check("stale_rsp", 32'(e.due), 32'(cyc));
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          if (e.port == 1'b0) begin exp_av = 1'b1; ea_rdata = e.data; end
          else                begin exp_bv = 1'b1; eb_rdata = e.data; end
        end
      end
      check("a_rvalid", a_rvalid, exp_av);
      check("b_rvalid", b_rvalid, exp_bv);
      check("a_rdata", a_rdata, ea_rdata);
      check("b_rdata", b_rdata, eb_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic av, input logic aw, input logic [14:0] aa, input logic [7:0] ad,
                         input logic bv, input logic bw, input logic [14:0] ba, input logic [7:0] bd);
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  // Called just after an accept edge; the response is due two edges later.
  task automatic push_exp(input logic port, input logic [7:0] data);
    exp_t e;
    e.due = cyc + 2;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
    $display("txn read port=%s data=0x%02h accepted cyc=%0d", port ? "B" : "A", data, cyc);
  endtask

  logic [14:0] addrs [4] = '{15'h0000, 15'h3FFF, 15'h4000, 15'h7FFF};
  logic [7:0]  datas [4] = '{8'hAB, 8'hAC, 8'hAD, 8'hAE};

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst cs_n", mem_cs_n, 1'b1);
    check("rst we_n", mem_we_n, 1'b1);
    check("rst oe_n", mem_oe_n, 1'b1);
    check("rst addr", mem_addr, 15'h0);
    check("rst din", mem_din, 8'h0);
    mon_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle: no valids, pins stay idle, no ready.
    repeat (2) begin
      tick();
      check("idle cs_n", mem_cs_n, 1'b1);
      check("idle we_n", mem_we_n, 1'b1);
      check("idle oe_n", mem_oe_n, 1'b1);
      check("idle a_ready", a_ready, 1'b0);
      check("idle b_ready", b_ready, 1'b0);
    end

    // Port A back-to-back writes across the address range.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b1, addrs[i], datas[i], 1'b0, 1'b0, 15'h0, 8'h0);
      #1;
      check("wr a_ready", a_ready, 1'b1);
      check("wr b_ready", b_ready, 1'b0);
      tick();
      $display("txn write port=A addr=0x%04h data=0x%02h", addrs[i], datas[i]);
      check("wr cs_n", mem_cs_n, 1'b0);
      check("wr we_n", mem_we_n, 1'b0);
      check("wr oe_n", mem_oe_n, 1'b1);
      check("wr addr", mem_addr, addrs[i]);
      check("wr din", mem_din, datas[i]);
    end

    // Port A back-to-back reads of the same addresses.
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b0, addrs[i], 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
      #1;
      check("rd a_ready", a_ready, 1'b1);
      tick();
      push_exp(1'b0, datas[i]);
      check("rd cs_n", mem_cs_n, 1'b0);
      check("rd we_n", mem_we_n, 1'b1);
      check("rd oe_n", mem_oe_n, 1'b0);
      check("rd addr", mem_addr, addrs[i]);
    end
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    tick();
    check("hold cs_n", mem_cs_n, 1'b1);
    check("hold addr", mem_addr, 15'h7FFF);
    check("hold din", mem_din, 8'hAE);
    repeat (3) tick();

    // Preload for the round-robin test, then an async reset mid-access.
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b1, 15'h4000, 8'h22);
    #1;
    check("pre b_ready", b_ready, 1'b1);
    check("pre a_ready", a_ready, 1'b0);
    tick();
    $display("txn write port=B addr=0x4000 data=0x22");
    set_req(1'b1, 1'b1, 15'h0000, 8'h11, 1'b0, 1'b0, 15'h0, 8'h0);
    #1;
    check("pre a_ready", a_ready, 1'b1);
    tick();
    $display("txn write port=A addr=0x0000 data=0x11");
    set_req(1'b1, 1'b1, 15'h0100, 8'h77, 1'b0, 1'b0, 15'h0, 8'h0);
    tick();
    $display("txn write port=A addr=0x0100 data=0x77 (cut by reset)");
    check("pre-rst cs_n", mem_cs_n, 1'b0);
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    #1;
    check("async cs_n", mem_cs_n, 1'b1);
    check("async we_n", mem_we_n, 1'b1);
    check("async oe_n", mem_oe_n, 1'b1);
    check("async addr", mem_addr, 15'h0);
    check("async din", mem_din, 8'h0);
    tick();
    rst_n = 1'b1;

    // Both ports read continuously: grants alternate starting with A.
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, 15'h0000, 8'h0, 1'b1, 1'b0, 15'h4000, 8'h0);
      #1;
      check("rr a_ready", a_ready, (i % 2 == 0));
      check("rr b_ready", b_ready, (i % 2 == 1));
      tick();
      if (i % 2 == 0) begin
        push_exp(1'b0, 8'h11);
        check("rr addr", mem_addr, 15'h0000);
      end else begin
        push_exp(1'b1, 8'h22);
        check("rr addr", mem_addr, 15'h4000);
      end
    end
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    repeat (3) tick();

    // Same-address hazard: write by B, read by A on the very next cycle.
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b1, 15'h1234, 8'h5A);
    #1;
    check("haz b_ready", b_ready, 1'b1);
    tick();
    $display("txn write port=B addr=0x1234 data=0x5A");
    set_req(1'b1, 1'b0, 15'h1234, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    #1;
    check("haz a_ready", a_ready, 1'b1);
    tick();
    push_exp(1'b0, 8'h5A);
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    repeat (3) tick();

    // Fixed priority: A wins every cycle while valid, B gets in afterwards.
    fx_a_valid = 1'b1;
    fx_b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("fx a_ready", fx_a_ready, 1'b1);
      check("fx b_ready", fx_b_ready, 1'b0);
      tick();
      check("fx addr A", fx_mem_addr, 15'h0011);
    end
    fx_a_valid = 1'b0;
    #1;
    check("fx b_ready late", fx_b_ready, 1'b1);
    check("fx a_ready late", fx_a_ready, 1'b0);
    tick();
    check("fx addr B", fx_mem_addr, 15'h0055);
    fx_b_valid = 1'b0;
    tick();

    // Reset with reads in flight: responses are dropped, pointer back to A.
    set_req(1'b1, 1'b1, 15'h0200, 8'h99, 1'b0, 1'b0, 15'h0, 8'h0);
    tick();
    $display("txn write port=A addr=0x0200 data=0x99");
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b1, 1'b0, 15'h4000, 8'h0);
    #1;
    check("fl b_ready", b_ready, 1'b1);
    tick();
    $display("txn read port=B addr=0x4000 (dropped by reset)");
    set_req(1'b1, 1'b0, 15'h0000, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    #1;
    check("fl a_ready", a_ready, 1'b1);
    tick();
    $display("txn read port=A addr=0x0000 (dropped by reset)");
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    set_req(1'b1, 1'b0, 15'h0000, 8'h0, 1'b1, 1'b0, 15'h4000, 8'h0);
    #1;
    check("post-rst a_ready", a_ready, 1'b1);
    check("post-rst b_ready", b_ready, 1'b0);
    tick();
    push_exp(1'b0, 8'h11);
    set_req(1'b0, 1'b0, 15'h0, 8'h0, 1'b0, 1'b0, 15'h0, 8'h0);
    repeat (4) tick();
    check("rsp queue empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-requester arbiter that shares one spram8 instance (32K x 8 single-port RAM, active-low cs_n/we_n/oe_n, registered read).
- Accepts at most one read or write per cycle using valid/ready handshakes.
- Drives the spram8 control, address and data pins from registers.
- Returns read data to the originating port after a fixed latency.
- Sits between CPU-side and peripheral/DMA-side masters and the spram8 wrapper.

Parameters:
- AW, 15, address width; matches spram8 addr.
- DW, 8, data width; matches spram8 data_in/data_out.
- RD_LAT, 1, spram8 read latency in clocks, from the sampling edge to data_out valid. Allowed range 1..3.
- ARB_MODE, 0, selects arbitration: 0 = round-robin, 1 = fixed priority to port A.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_rvalid  out  1  port A read data valid (1-cycle pulse).
- a_rdata  out  DW  port A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: port B, identical to port A.
- mem_cs_n  out  1  to spram8 cs_n.
- mem_we_n  out  1  to spram8 we_n.
- mem_oe_n  out  1  to spram8 oe_n.
- mem_addr  out  AW  to spram8 addr.
- mem_din  out  DW  to spram8 data_in.
- mem_dout  in  DW  from spram8 data_out.

Behaviour:
- Reset (async assert, sync release):
  - mem_cs_n = mem_we_n = mem_oe_n = 1; mem_addr = 0; mem_din = 0.
  - a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - RR pointer = A; response pipeline cleared.
- Handshake:
  - A transfer occurs on a rising edge where x_valid and x_ready are both 1.
  - x_ready is combinational from the grant and depends only on the valid inputs and the RR pointer.
  - x_ready is never 1 while x_valid is 0.
  - At most one of a_ready and b_ready is 1 in any cycle.
- Arbitration, ARB_MODE=0:
  - Only one port valid: that port is granted.
  - Both valid: the port named by the RR pointer is granted.
  - The pointer moves to the other port after each grant.
  - Worst-case wait is one grant.
- Arbitration, ARB_MODE=1: A is always granted when a_valid=1; B can starve (documented, intended).
- Memory drive (registered at the accept edge E0):
  - Read: cs_n=0, oe_n=0, we_n=1, addr=req addr.
  - Write: cs_n=0, we_n=0, oe_n=1, addr and din = req values.
  - No accept: cs_n=we_n=oe_n=1; addr and din hold their last values.
  - spram8 samples at E0+1.
- Read return:
  - Tag pipeline of depth RD_LAT+1 carries {valid, port}.
  - mem_dout is captured into x_rdata, and x_rvalid pulses high for one cycle, starting at edge E0+RD_LAT+1. This is 2 edges with the default RD_LAT.
  - The non-target port's rdata holds its previous value.
- Writes produce no response; a write is complete at accept.
- Throughput: one access per cycle, back-to-back, any mix of ports and read/write. Requests are never stalled by in-flight reads.
- Ordering: memory order equals grant order. A read granted after a write to the same address returns the new data, including the next-cycle case.
- Requesters must accept responses unconditionally; there is no rvalid backpressure.
- Address is passed unmodified; wrap at 0x7FFF is not the arbiter's concern.
- Reset mid-operation: in-flight reads are discarded, with no rvalid after rst_n deasserts. Memory pins go idle immediately (async).
- Request inputs are ignored while rst_n=0.

Decomposition:
- Include file spram_arb_defs.vh holds:
  - PORT_A=1'b0 and PORT_B=1'b1;
  - ARB_RR=0 and ARB_FIXED=1;
  - idle pin encoding constants.
- Sub-module spram_rsp_pipe: parameterized RD_LAT+1 deep shift register of {valid, port}, with async reset. Its output selects which port's rdata/rvalid is loaded.

Test Plan:
- Reset then idle, no valids:
  - mem_cs_n/we_n/oe_n stay 1 and a_ready=b_ready=0.
  - Assert rst_n=0 mid-run; pins go to 1 without waiting for a clock edge.
- Port A writes 0x0000=0xAB, 0x3FFF=0xAC, 0x4000=0xAD, 0x7FFF=0xAE on consecutive cycles, then reads the same addresses:
  - a_rvalid pulses 4 consecutive cycles with 0xAB, 0xAC, 0xAD, 0xAE.
  - Each pulse lands exactly 2 edges after its accept.
- Both ports read continuously, ARB_MODE=0 (A addr 0x0000, B addr 0x4000, preloaded 0x11/0x22):
  - Grants alternate A,B,A,B starting with A after reset.
  - a_rdata=0x11 and b_rdata=0x22, each on its own port only.
- ARB_MODE=1, both valid for 5 cycles: a_ready=1 in all 5 cycles, b_ready=0; B is granted in the cycle a_valid drops.
- Same-address hazard: B writes 0x1234=0x5A, then A reads 0x1234 in the next cycle; a_rdata=0x5A.
- Reset while two reads are in flight, with rst_n low for 1 cycle after the accepts: no a_rvalid/b_rvalid pulse ever appears, and the RR pointer restarts at A.
